// File: rtl/scan_rx_if.sv
// Scan receiver port bundle: frame start, serial data and the word handshake.
// master = the side driving the scan stream and acking; slave = the receiver.
interface scan_rx_if #(
  parameter int unsigned WIDTH = 19
);
  logic             en;
  logic             scan_in;
  logic             data_ack;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             busy;
  logic             overrun;
  logic             err;

  modport master (
    output en, scan_in, data_ack,
    input  data, data_valid, busy, overrun, err
  );

  modport slave (
    input  en, scan_in, data_ack,
    output data, data_valid, busy, overrun, err
  );
endinterface

// File: rtl/scan_rx.sv
// Serial scan receiver: detects the en rising edge, shifts WIDTH bits in LSB-first
// and presents the word with a valid/ack handshake. Optional macro SCAN_RX_PARITY_EN.
module scan_rx #(
  parameter int unsigned WIDTH = 19
) (
  input  logic      clk,
  input  logic      rst,
  scan_rx_if.slave  bus
);

`ifdef SCAN_RX_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAME-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_en_q, last_en_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic             start_c;
  logic             ack_c;
  logic             done_c;
  logic [FRAME-1:0] word_c;

  assign start_c = bus.en & ~last_en_q;
  assign ack_c   = bus.data_ack & data_valid_q;
  // Completed word includes the bit sampled on the completion edge itself.
  assign word_c  = {bus.scan_in, shreg_q[FRAME-1:1]};
  assign done_c  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // Next-state, shift and handshake logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    last_en_d    = bus.en;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d = word_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (done_c) begin
          state_d = ST_IDLE;
        end
        // A new start aborts (or, on the last edge, follows) the current frame.
        if (start_c) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ack_c) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (done_c) begin
      data_d       = word_c[WIDTH-1:0];
      data_valid_d = 1'b1;
      if (data_valid_q && !bus.data_ack) begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      // High so that en held through reset is not seen as a rising edge.
      last_en_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      last_en_q    <= last_en_d;
    end
  end

`ifdef SCAN_RX_PARITY_EN
  logic err_q, err_d;

  // Even parity over payload and parity bit; held until the next completion.
  always_comb begin
    err_d = err_q;
    if (done_c) begin
      err_d = ^word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_scan_rx.sv
// Bench for scan_rx: edge-indexed reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized stream.
module tb_scan_rx;
  localparam int unsigned WIDTH = 19;
`ifdef SCAN_RX_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  scan_rx_if #(.WIDTH(WIDTH)) bus();

  scan_rx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames tracked by the edge index of their start.
  int              n = 0;
  int              e0 = -1;
  logic            m_prev_en = 1'b1;
  logic [63:0]     m_word = '0;
  logic [WIDTH-1:0] m_data = '0;
  logic            m_valid = 1'b0;
  logic            m_ovr = 1'b0;
  logic            m_err = 1'b0;
  logic            m_busy = 1'b0;
  logic            chk = 1'b0;

  always @(posedge clk) begin : model
    logic st, comp, ack, old_valid;
    int   k;
    if (rst) begin
      e0 = -1; m_prev_en = 1'b1; m_word = '0; m_data = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      chk = 1'b1;
    end else begin
      st        = bus.en && !m_prev_en;
      ack       = bus.data_ack && m_valid;
      old_valid = m_valid;
      comp      = 1'b0;
      if (e0 >= 0) begin
        k = n - e0 - 1;
        if (bus.scan_in) m_word = m_word | (64'd1 << k);
        if (k == int'(FRAME) - 1) comp = 1'b1;
      end
      if (ack) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (comp) begin
        if (old_valid && !bus.data_ack) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = m_word[WIDTH-1:0];
`ifdef SCAN_RX_PARITY_EN
        m_err   = ($countones(m_word) % 2) == 1;
`endif
        e0 = -1;
      end
      if (st) begin
        e0     = n;
        m_word = '0;
      end
      m_busy    = (e0 >= 0);
      m_prev_en = bus.en;
    end
    n++;
  end

  always @(negedge clk) begin
    if (chk) begin
      check("data", 64'(bus.data), 64'(m_data));
      check("data_valid", 64'(bus.data_valid), 64'(m_valid));
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("overrun", 64'(bus.overrun), 64'(m_ovr));
      check("err", 64'(bus.err), 64'(m_err));
    end
  end

  int busy_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int lo, input int hi, input bit ack_last);
    for (int k = lo; k <= hi; k++) begin
      bus.scan_in  = w[k];
      bus.data_ack = ack_last && (k == hi);
      if (bus.busy) busy_cnt++;
      tick();
    end
    bus.data_ack = 1'b0;
  endtask

  function automatic logic [31:0] frame_of(input logic [WIDTH-1:0] p, input logic par);
    return 32'(p) | (32'(par) << WIDTH);
  endfunction

  task automatic send_frame(input logic [WIDTH-1:0] p, input bit ack_last);
    start_pulse();
    send_bits(frame_of(p, ^p), 0, int'(FRAME) - 1, ack_last);
  endtask

  task automatic ack_pulse();
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.scan_in = 1'b0; bus.data_ack = 1'b0;
    busy_cnt = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset data", 64'(bus.data), 64'h0);
    check("reset valid", 64'(bus.data_valid), 64'h0);
    check("reset busy", 64'(bus.busy), 64'h0);
    check("reset overrun", 64'(bus.overrun), 64'h0);
    check("reset err", 64'(bus.err), 64'h0);

    // Single frame.
    start_pulse();
    busy_cnt = 0;
    send_bits(frame_of(19'h5A5A3, ^19'h5A5A3), 0, int'(FRAME) - 1, 1'b0);
    check("t1 data", 64'(bus.data), 64'h5A5A3);
    check("t1 valid", 64'(bus.data_valid), 64'h1);
    check("t1 busy", 64'(bus.busy), 64'h0);
    check("t1 busy cycles", 64'(busy_cnt), 64'(FRAME));

    // Overrun, then ack clears valid and overrun.
    ack_pulse();
    send_frame(19'h00001, 1'b0);
    send_frame(19'h7FFFF, 1'b0);
    check("t2 data", 64'(bus.data), 64'h7FFFF);
    check("t2 overrun", 64'(bus.overrun), 64'h1);
    check("t2 valid", 64'(bus.data_valid), 64'h1);
    ack_pulse();
    check("t2 ack valid", 64'(bus.data_valid), 64'h0);
    check("t2 ack overrun", 64'(bus.overrun), 64'h0);

    // Ack on the completion edge of the second frame.
    send_frame(19'h12345, 1'b0);
    send_frame(19'h6BCDE, 1'b1);
    check("t3 valid", 64'(bus.data_valid), 64'h1);
    check("t3 data", 64'(bus.data), 64'h6BCDE);
    check("t3 overrun", 64'(bus.overrun), 64'h0);
    ack_pulse();

    // Restart after bit 10.
    start_pulse();
    send_bits(frame_of(19'h2AAAA, ^19'h2AAAA), 0, 10, 1'b0);
    start_pulse();
    send_bits(frame_of(19'h13579, ^19'h13579), 0, 6, 1'b0);
    check("t4 no valid at old E0+19", 64'(bus.data_valid), 64'h0);
    check("t4 busy", 64'(bus.busy), 64'h1);
    send_bits(frame_of(19'h13579, ^19'h13579), 7, int'(FRAME) - 1, 1'b0);
    check("t4 valid", 64'(bus.data_valid), 64'h1);
    check("t4 data", 64'(bus.data), 64'h13579);

    // Reset mid-frame with en held high through and after reset.
    start_pulse();
    send_bits(32'h0003F, 0, 6, 1'b0);
    bus.en = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5 busy", 64'(bus.busy), 64'h0);
      check("t5 valid", 64'(bus.data_valid), 64'h0);
      check("t5 data", 64'(bus.data), 64'h0);
      check("t5 overrun", 64'(bus.overrun), 64'h0);
    end
    bus.en = 1'b0;
    tick(); tick();
    check("t5 still idle", 64'(bus.busy), 64'h0);

`ifdef SCAN_RX_PARITY_EN
    start_pulse();
    send_bits(frame_of(19'h00001, 1'b1), 0, int'(FRAME) - 1, 1'b0);
    check("par good valid", 64'(bus.data_valid), 64'h1);
    check("par good err", 64'(bus.err), 64'h0);
    start_pulse();
    send_bits(frame_of(19'h00001, 1'b0), 0, int'(FRAME) - 1, 1'b0);
    check("par bad err", 64'(bus.err), 64'h1);
    ack_pulse();
    check("par err held after ack", 64'(bus.err), 64'h1);
`endif

    // Randomized stream: sparse en pulses, random data, acks and resets.
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 499) == 0);
      bus.en       = ($urandom_range(0, 27) == 0) || (bus.en && ($urandom_range(0, 2) == 0));
      bus.scan_in  = 1'($urandom_range(0, 1));
      bus.data_ack = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0; bus.en = 1'b0; bus.data_ack = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scan_rx.md
# scan_rx

Serial scan receiver for the toy CPU's debug/scan path. It is the receiving end of the one-bit scan stream: it detects the same `en` rising edge that starts a transmit frame, shifts in WIDTH bits LSB-first from `scan_in`, and presents the reassembled word with a valid/ack handshake. It sits on the bench/debug side of the scan link, or on-chip for loopback, and is clocked by the same `clk` as the transmitter.

## Interface
- `WIDTH`, default 19: frame payload width in bits. Legal range 2..31.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `en`  in  1: frame start. A rising edge, sampled, starts a frame.
- `scan_in`  in  1: serial data, LSB first, one bit per cycle.
- `data_ack`  in  1: consumer acknowledge. Clears `data_valid`.
- `data`  out  WIDTH: last complete frame.
- `data_valid`  out  1: `data` holds an unacknowledged frame.
- `busy`  out  1: a frame is being received.
- `overrun`  out  1: sticky. A frame completed while `data_valid` was already set.
- `err`  out  1: parity error for the frame in `data`. Constant 0 unless parity is compiled in.

## Operation
- Edge detect:
  - `last_en` is a register of `en`.
  - `start = en & !last_en`, evaluated at a clock edge.
  - `en` falling or staying high mid-frame has no effect.
- FSM has two states:
  - IDLE → SHIFT on `start`. The bit counter `cnt` (5 bits) is cleared to 0 and the shift register is untouched.
  - SHIFT: at each edge, `shreg <= {scan_in, shreg[WIDTH-1:1]}` and `cnt <= cnt+1`.
  - SHIFT → IDLE when the final bit is sampled (`cnt == FRAME-1`). FRAME = WIDTH, or WIDTH+1 with parity.
  - On that edge, `data` is loaded with the completed word, including the bit sampled on that same edge, and `data_valid` is set.
- `start` while in SHIFT aborts the current frame and restarts with `cnt=0`. No completion occurs for the aborted frame.
- `busy` = 1 exactly while the state is SHIFT.
- Handshake and overrun:
  - `data_ack` while `data_valid` clears `data_valid` on the next edge. It also clears `overrun`.
  - `data_ack` while `data_valid` = 0 is ignored.
  - A completion while `data_valid` = 1 and no ack on the same edge: `data` is overwritten and `overrun` is set.
  - A completion on the same edge as an ack: `data` is updated, `data_valid` stays 1, `overrun` is not set.
- Reset values:
  - `data` = 0, `data_valid` = 0, `busy` = 0, `overrun` = 0, `err` = 0.
  - FSM = IDLE, `cnt` = 0.
  - `last_en` = 1, so an `en` held high through reset does not start a frame.
- Reset mid-frame discards the partial frame.

## Timing
- Let E0 be the edge where `start` is true.
- Bit k is sampled at edge E0+1+k, for k = 0..FRAME-1. This matches a transmitter that loads on E0 and shifts once per edge.
- `data` and `data_valid` update at edge E0+FRAME and are visible in the following cycle.
- Latency is FRAME cycles from the detect edge.
- `busy` is high in the cycles after E0 through edge E0+FRAME.
- `start` coinciding with the completion edge: the completion is performed and the new frame starts with `cnt=0`.
- Back-to-back frames need `en` low for at least one sampled edge between rises.

## Configuration
- `SCAN_RX_PARITY_EN` defined:
  - FRAME = WIDTH+1. Bit index WIDTH is an even-parity bit over the payload.
  - At completion, `err <= ^payload ^ parity_bit`.
  - `err` updates only at completion; ack does not clear it.
- `SCAN_RX_PARITY_EN` undefined:
  - FRAME = WIDTH.
  - `err` is tied to 0. No extra register exists.

## Test plan
- Reset, raise `en` for 1 cycle, drive 19'h5A5A3 LSB-first from E0+1 → at E0+19: `data` = 19'h5A5A3, `data_valid` = 1, `busy` = 0. `busy` was 1 for 19 cycles.
- Two frames, 19'h00001 then 19'h7FFFF, with no ack → `data` = 19'h7FFFF, `overrun` = 1. Then pulse `data_ack` → `data_valid` = 0 and `overrun` = 0 next cycle.
- Ack asserted on the completion edge of the second frame → `data_valid` stays 1 with the new data, and `overrun` = 0.
- Re-raise `en` after bit 10 of a frame → no valid at the original E0+19. Valid occurs exactly 19 edges after the restart edge, carrying the restarted payload.
- `rst` at bit 7, with `en` held high through reset and 5 cycles beyond → all outputs 0, `busy` stays 0, and no frame starts.
- With `SCAN_RX_PARITY_EN`, send 19'h00001 with parity bit 1 → at E0+20: `data_valid` = 1, `err` = 0. Resend with parity bit 0 → `err` = 1.
